// File: rtl/timer_display_driver.sv
// Two-digit multiplexed seven-segment driver for the traffic-light countdown.
// A sequential double-dabble unit converts the 0..99 s value to BCD only when
// the value changes. A free-running scan counter alternates the two digits.
module timer_display_driver #(
  parameter int unsigned SCAN_DIV       = 50000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] timeRemaining,
  input  logic       enable,
  output logic [6:0] segments,
  output logic [1:0] digitSelect,
  output logic       busy
);

  localparam int unsigned CNT_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned ITER_LAST = 6;
  localparam logic [6:0]  SEG_DASH  = 7'b1000000;
  localparam logic [6:0]  SEG_MASK  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [1:0]  DIG_MASK  = SEG_ACTIVE_LOW ? 2'b11 : 2'b00;
  localparam logic        UNITS     = 1'b0;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [6:0]       in_reg;
  logic [6:0]       shown_value;
  logic [6:0]       conv_value;
  logic [14:0]      sr;
  logic [2:0]       iter;
  logic [3:0]       tens, units;
  logic             ovf;
  logic             load_shift, set_ovf, do_shift, finish;
  logic [CNT_W-1:0] scan_cnt;
  logic             active_digit;
  logic [6:0]       seg_nxt;
  logic [1:0]       dig_nxt;

  // One double-dabble iteration: add 3 to BCD nibbles >= 5, then shift left.
  function automatic logic [14:0] dd_step(input logic [14:0] v);
    logic [14:0] t;
    t = v;
    if (t[10:7] >= 4'd5)  t[10:7]  = t[10:7] + 4'd3;
    if (t[14:11] >= 4'd5) t[14:11] = t[14:11] + 4'd3;
    return {t[13:0], 1'b0};
  endfunction

  // Active-high gfedcba pattern; anything outside 0..9 is blank.
  function automatic logic [6:0] seg_pat(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'b0111111;
      4'd1:    p = 7'b0000110;
      4'd2:    p = 7'b1011011;
      4'd3:    p = 7'b1001111;
      4'd4:    p = 7'b1100110;
      4'd5:    p = 7'b1101101;
      4'd6:    p = 7'b1111101;
      4'd7:    p = 7'b0000111;
      4'd8:    p = 7'b1111111;
      4'd9:    p = 7'b1101111;
      default: p = 7'b0000000;
    endcase
    return p;
  endfunction

  // Conversion FSM state register; busy follows the next state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);
    end
  end

  // Next-state and datapath strobes.
  always_comb begin
    state_nxt  = state;
    load_shift = 1'b0;
    set_ovf    = 1'b0;
    do_shift   = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (in_reg != shown_value) begin
          if (in_reg <= 7'd99) begin
            load_shift = 1'b1;
            state_nxt  = SHIFT;
          end else begin
            set_ovf   = 1'b1;
            state_nxt = DONE;
          end
        end
      end
      SHIFT: begin
        do_shift = 1'b1;
        if (iter == 3'(ITER_LAST)) state_nxt = DONE;
      end
      DONE: begin
        finish    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Input capture and conversion datapath.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      in_reg      <= '0;
      shown_value <= '0;
      conv_value  <= '0;
      sr          <= '0;
      iter        <= '0;
      tens        <= '0;
      units       <= '0;
      ovf         <= 1'b0;
    end else begin
      in_reg <= timeRemaining;
      if (load_shift) begin
        sr         <= {8'b0, in_reg};
        iter       <= '0;
        conv_value <= in_reg;
      end
      if (set_ovf) begin
        ovf         <= 1'b1;
        shown_value <= in_reg;
        conv_value  <= in_reg;
      end
      if (do_shift) begin
        sr   <= dd_step(sr);
        iter <= iter + 3'd1;
      end
      if (finish) begin
        shown_value <= conv_value;
        if (conv_value <= 7'd99) begin
          tens  <= sr[14:11];
          units <= sr[10:7];
          ovf   <= 1'b0;
        end
      end
    end
  end

  // Free-running digit scan, independent of the FSM and of enable.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      scan_cnt     <= '0;
      active_digit <= UNITS;
    end else if (scan_cnt == CNT_W'(SCAN_DIV - 1)) begin
      scan_cnt     <= '0;
      active_digit <= ~active_digit;
    end else begin
      scan_cnt <= scan_cnt + CNT_W'(1);
    end
  end

  // Active-high digit/segment selection with dash and leading-zero blanking.
  always_comb begin
    seg_nxt = 7'b0000000;
    dig_nxt = 2'b00;
    if (enable) begin
      if (active_digit == UNITS) begin
        dig_nxt = 2'b01;
        seg_nxt = ovf ? SEG_DASH : seg_pat(units);
      end else begin
        dig_nxt = 2'b10;
        if (ovf)               seg_nxt = SEG_DASH;
        else if (tens != 4'd0) seg_nxt = seg_pat(tens);
      end
    end
  end

  // Output registers; both come from the same active_digit so they switch together.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      segments    <= SEG_MASK;
      digitSelect <= DIG_MASK;
    end else begin
      segments    <= seg_nxt ^ SEG_MASK;
      digitSelect <= dig_nxt ^ DIG_MASK;
    end
  end

endmodule

// File: tb/tb_timer_display_driver.sv
// Scoreboard bench for timer_display_driver (SCAN_DIV=4, active-low outputs).
module tb_timer_display_driver;

  localparam int unsigned SCAN_DIV = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] timeRemaining = 7'd0;
  logic       enable = 1'b1;
  logic [6:0] segments;
  logic [1:0] digitSelect;
  logic       busy;

  int total = 0;
  int bad = 0;
  int bad_pat = 0;
  int ecnt = 0;

  typedef struct {
    logic [6:0] tens;
    logic [6:0] units;
  } exp_t;
  exp_t sb[$];

  timer_display_driver #(.SCAN_DIV(SCAN_DIV), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clock(clock),
    .reset(reset),
    .timeRemaining(timeRemaining),
    .enable(enable),
    .segments(segments),
    .digitSelect(digitSelect),
    .busy(busy)
  );

  always #5 clock = ~clock;

  // Edges since reset release; drives the bench's scan-phase model.
  always @(posedge clock or posedge reset) begin
    if (reset) ecnt <= 0;
    else       ecnt <= ecnt + 1;
  end

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [6:0] exp_tens(input int v);
    if (v > 99) return ~7'h40;
    if (v / 10 == 0) return 7'h7F;
    return ~seg_of(4'(v / 10));
  endfunction

  function automatic logic [6:0] exp_units(input int v);
    if (v > 99) return ~7'h40;
    return ~seg_of(4'(v % 10));
  endfunction

  function automatic bit pat_ok(input logic [6:0] s, input logic [1:0] d);
    if (d == 2'b01 && s == 7'h7F) return 1'b1;
    if (s == ~7'h40) return 1'b1;
    for (int i = 0; i < 10; i++) if (s == ~seg_of(4'(i))) return 1'b1;
    return 1'b0;
  endfunction

  // Every lit cycle must show a legal digit, a dash, or a blanked tens slot.
  always @(negedge clock) begin
    if (!reset && enable && digitSelect != 2'b11 && !pat_ok(segments, digitSelect))
      bad_pat <= bad_pat + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_value(input int v);
    exp_t e;
    timeRemaining = 7'(v);
    e.tens  = exp_tens(v);
    e.units = exp_units(v);
    sb.push_back(e);
  endtask

  task automatic wait_settled(input string tag);
    int quiet = 0;
    bit ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (!busy) quiet++;
      else quiet = 0;
      if (quiet >= 3) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq({tag, "_settle"}, 32'(ok), 32'd1);
  endtask

  task automatic check_display(input string tag);
    logic [6:0] t_obs;
    logic [6:0] u_obs;
    exp_t e;
    t_obs = 'x;
    u_obs = 'x;
    if (sb.size() == 0) begin
      check_eq({tag, "_sb_empty"}, 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    for (int i = 0; i < 2 * SCAN_DIV + 2; i++) begin
      tick();
      if (digitSelect == 2'b01) t_obs = segments;
      else if (digitSelect == 2'b10) u_obs = segments;
    end
    check_eq({tag, "_tens"}, 32'(t_obs), 32'(e.tens));
    check_eq({tag, "_units"}, 32'(u_obs), 32'(e.units));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int rise, fall, rises, viol, a, b, k;
    logic prev;
    logic [1:0] dprev;
    logic [1:0] exp_dig;

    // Reset state
    repeat (3) tick();
    check_eq("rst_seg", 32'(segments), 32'h7F);
    check_eq("rst_dig", 32'(digitSelect), 32'h3);
    check_eq("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    tick();
    check_eq("first_dig", 32'(digitSelect), 32'h2);
    check_eq("first_seg", 32'(segments), 32'h40);
    push_value(0);
    check_display("zero");

    // Conversion of 87: busy rises at N+1 and falls at N+9
    tick();
    push_value(87);
    rise = -1;
    fall = -1;
    for (int i = 0; i < 13; i++) begin
      tick();
      if (busy && rise < 0) rise = i;
      if (!busy && rise >= 0 && fall < 0) fall = i;
    end
    check_eq("busy_rise_edge", 32'(rise), 32'd1);
    check_eq("busy_fall_edge", 32'(fall), 32'd9);
    wait_settled("c87");
    check_display("c87");

    // Scan period: digitSelect holds for SCAN_DIV cycles
    a = -1;
    b = -1;
    dprev = digitSelect;
    for (int i = 0; i < 3 * SCAN_DIV + 1; i++) begin
      tick();
      if (digitSelect != dprev) begin
        if (a < 0) a = i;
        else if (b < 0) b = i;
      end
      dprev = digitSelect;
    end
    check_eq("scan_period", 32'(b - a), 32'(SCAN_DIV));

    // Leading-zero blanking
    push_value(5);
    wait_settled("c5");
    check_display("c5");

    // Overflow then recovery
    push_value(120);
    repeat (3) tick();
    check_eq("ovf_dash_n3", 32'(segments), 32'h3F);
    check_eq("ovf_dig_lit", 32'(digitSelect == 2'b11), 32'd0);
    wait_settled("c120");
    check_display("c120");
    push_value(42);
    wait_settled("c42");
    check_display("c42");

    // Changes during SHIFT: 29 is skipped, 28 is converted after 30
    tick();
    timeRemaining = 7'd30;
    rises = 0;
    prev = busy;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (busy && !prev) rises++;
      prev = busy;
      if (i == 1) timeRemaining = 7'd29;
      if (i == 3) push_value(28);
    end
    check_eq("chg_conversions", 32'(rises), 32'd2);
    wait_settled("c28");
    check_display("c28");

    // Disable blanks outputs; scan keeps running underneath
    enable = 1'b0;
    viol = 0;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (digitSelect != 2'b11 || segments != 7'h7F) viol++;
    end
    check_eq("disable_blank", 32'(viol), 32'd0);
    enable = 1'b1;
    tick();
    k = ecnt;
    exp_dig = (((k - 1) / SCAN_DIV) % 2 == 0) ? 2'b10 : 2'b01;
    check_eq("reen_dig", 32'(digitSelect), 32'(exp_dig));
    check_eq("reen_seg", 32'(segments), 32'((exp_dig == 2'b10) ? exp_units(28) : exp_tens(28)));

    // Reset asserted mid-SHIFT takes effect asynchronously
    timeRemaining = 7'd63;
    repeat (3) tick();
    #2;
    reset = 1'b1;
    #1;
    check_eq("async_rst_busy", 32'(busy), 32'd0);
    check_eq("async_rst_seg", 32'(segments), 32'h7F);
    check_eq("async_rst_dig", 32'(digitSelect), 32'h3);
    timeRemaining = 7'd0;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    check_eq("rerel_dig", 32'(digitSelect), 32'h2);
    check_eq("rerel_seg", 32'(segments), 32'h40);
    push_value(0);
    check_display("rerel");

    check_eq("pattern_valid", 32'(bad_pat), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
